// File: rtl/window_gather.sv
// window_gather: gathers NUM_INPUT signed samples into a window; in: clk, rst_n, in_valid, in_data, flush, out_ready; out: in_ready, out_valid, out_data[0..N-1] (0 = oldest)
module window_gather #(
  parameter int NUM_INPUT = 2,
  parameter int WIDTH_IN  = 8,
  parameter bit SLIDING   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [WIDTH_IN-1:0] in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WIDTH_IN-1:0] out_data [NUM_INPUT]
);
  localparam int CW = $clog2(NUM_INPUT + 1);
  typedef enum logic [1:0] {FILL, FULL, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [WIDTH_IN-1:0] data_q [NUM_INPUT];
  logic signed [WIDTH_IN-1:0] data_d [NUM_INPUT];
  logic in_acc, out_acc;
  if (NUM_INPUT < 1 || WIDTH_IN < 1) begin : g_bad_params
    $error("window_gather: NUM_INPUT and WIDTH_IN must both be >= 1");
  end
  assign in_ready  = rst_n && !flush && (state_q != FULL || (SLIDING && out_ready));
  assign out_valid = state_q == FULL;
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;
  assign out_data  = data_q;
  always_comb begin
    data_d  = data_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_acc) begin
      for (int k = 0; k < NUM_INPUT - 1; k++) data_d[k] = data_q[k+1];
      data_d[NUM_INPUT-1] = in_data;
    end
    if (flush) begin
      state_d = FILL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FILL: if (in_acc) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_d == CW'(NUM_INPUT)) ? FULL : FILL;
        end
        FULL: if (out_acc) begin
          if (!SLIDING) begin
            state_d = FILL;
            cnt_d   = '0;
          end else if (!in_acc) state_d = HOLD;
        end
        HOLD: if (in_acc) state_d = FULL;
        default: state_d = FILL;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      for (int k = 0; k < NUM_INPUT; k++) data_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_window_gather.sv
// tb_window_gather: four window_gather configurations checked against a queue-based window model
module tb_window_gather;
  localparam int NN [4] = '{4, 4, 2, 1};
  localparam bit SS [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic clk = 1'b0;
  logic rst_n;
  logic iv [4], fl [4], ordy [4], gate [4], ovv [4], irv [4];
  logic signed [7:0] idt [4];
  logic ov0, ov1, ov2, ov3, ir0, ir1, ir2, ir3;
  logic signed [7:0] od0 [4];
  logic signed [7:0] od1 [4];
  logic signed [7:0] od2 [2];
  logic signed [7:0] od3 [1];
  logic signed [7:0] obs [4][4];
  logic signed [7:0] hist [4][$];
  logic signed [7:0] seq [4][$];
  bit pend [4];
  int wins [4];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  window_gather #(.NUM_INPUT(4), .WIDTH_IN(8), .SLIDING(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .in_data(idt[0]), .flush(fl[0]), .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0));
  window_gather #(.NUM_INPUT(4), .WIDTH_IN(8), .SLIDING(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .in_data(idt[1]), .flush(fl[1]), .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1));
  window_gather #(.NUM_INPUT(2), .WIDTH_IN(8), .SLIDING(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .in_data(idt[2]), .flush(fl[2]), .out_valid(ov2), .out_ready(ordy[2]), .out_data(od2));
  window_gather #(.NUM_INPUT(1), .WIDTH_IN(8), .SLIDING(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir3), .in_data(idt[3]), .flush(fl[3]), .out_valid(ov3), .out_ready(ordy[3]), .out_data(od3));
  always_comb begin
    for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) obs[i][k] = '0;
    for (int k = 0; k < 4; k++) begin
      obs[0][k] = od0[k];
      obs[1][k] = od1[k];
    end
    for (int k = 0; k < 2; k++) obs[2][k] = od2[k];
    obs[3][0] = od3[0];
    ovv = '{ov0, ov1, ov2, ov3};
    irv = '{ir0, ir1, ir2, ir3};
  end
  task automatic chk(string tag, int i, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, i, $signed(o), $signed(e));
    end
  endtask
  task automatic model_step(int i);
    bit er, ai, ao;
    er = !fl[i] && (!pend[i] || (SS[i] && ordy[i]));
    chk("out_valid", i, 32'(ovv[i]), 32'(pend[i]));
    chk("in_ready", i, 32'(irv[i]), 32'(er));
    if (pend[i]) for (int k = 0; k < NN[i]; k++) chk("out_data", i, int'(obs[i][k]), int'(hist[i][k]));
    ai = iv[i] && er;
    ao = pend[i] && ordy[i] && !fl[i];
    if (ai) void'(seq[i].pop_front());
    if (ao) wins[i]++;
    if (fl[i]) begin
      hist[i].delete();
      pend[i] = 1'b0;
    end else if (SS[i]) begin
      if (ai) begin
        hist[i].push_back(idt[i]);
        if (hist[i].size() > NN[i]) void'(hist[i].pop_front());
      end
      pend[i] = (ai && hist[i].size() == NN[i]) || (pend[i] && !ao);
    end else if (pend[i]) begin
      if (ao) begin
        pend[i] = 1'b0;
        hist[i].delete();
      end
    end else if (ai) begin
      hist[i].push_back(idt[i]);
      pend[i] = hist[i].size() == NN[i];
    end
  endtask
  task automatic cycle();
    for (int i = 0; i < 4; i++) begin
      iv[i]  = gate[i] && seq[i].size() > 0;
      idt[i] = iv[i] ? seq[i][0] : 8'($urandom);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) model_step(i);
    @(posedge clk);
    #1;
  endtask
  task automatic reset_chk();
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", i, 32'(ovv[i]), 32'd0);
      chk("rst_ready", i, 32'(irv[i]), 32'd0);
      for (int k = 0; k < NN[i]; k++) chk("rst_data", i, int'(obs[i][k]), 32'd0);
    end
  endtask
  function automatic logic [31:0] win0();
    return {obs[0][0], obs[0][1], obs[0][2], obs[0][3]};
  endfunction
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1; gate[i] = 1'b1; idt[i] = '0;
      pend[i] = 1'b0; wins[i] = 0;
    end
    #2 reset_chk();
    #5 rst_n = 1'b1;
    for (int v = 1; v <= 5; v++) seq[0].push_back(8'(v));
    for (int v = 1; v <= 8; v++) seq[1].push_back(8'(v));
    seq[2].push_back(-8'sd128);
    seq[2].push_back(8'sd127);
    for (int v = 7; v <= 9; v++) seq[3].push_back(8'(v));
    repeat (4) cycle();
    chk("win_1234", 0, win0(), {8'd1, 8'd2, 8'd3, 8'd4});
    cycle();
    chk("win_2345", 0, win0(), {8'd2, 8'd3, 8'd4, 8'd5});
    repeat (9) cycle();
    chk("wins_slide", 0, wins[0], 2);
    chk("wins_block", 1, wins[1], 2);
    chk("wins_minmax", 2, wins[2], 1);
    chk("wins_n1", 3, wins[3], 3);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        gate[i] = $urandom_range(0, 3) != 0;
        ordy[i] = $urandom_range(0, 3) != 0;
        fl[i]   = $urandom_range(0, 24) == 0;
        if (seq[i].size() < 2) seq[i].push_back(8'($urandom));
      end
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      gate[i] = 1'b1; fl[i] = 1'b1; ordy[i] = 1'b1; seq[i].delete();
    end
    cycle();
    for (int i = 0; i < 4; i++) begin
      fl[i] = 1'b0;
      seq[i].push_back(8'sd1);
      seq[i].push_back(8'sd2);
    end
    ordy[0] = 1'b0;
    repeat (2) cycle();
    for (int i = 0; i < 4; i++) begin
      seq[i].push_back(8'sd9);
      fl[i] = 1'b1;
    end
    cycle();
    for (int i = 0; i < 4; i++) begin
      fl[i] = 1'b0;
      seq[i].delete();
      for (int v = 3; v <= 6; v++) seq[i].push_back(8'(v));
    end
    repeat (4) cycle();
    chk("flush_valid", 0, 32'(ovv[0]), 32'd1);
    chk("win_3456", 0, win0(), {8'd3, 8'd4, 8'd5, 8'd6});
    seq[0].push_back(8'sd7);
    repeat (3) cycle();
    chk("stall_ready", 0, 32'(irv[0]), 32'd0);
    chk("win_stable", 0, win0(), {8'd3, 8'd4, 8'd5, 8'd6});
    ordy[0] = 1'b1;
    cycle();
    chk("win_4567", 0, win0(), {8'd4, 8'd5, 8'd6, 8'd7});
    for (int i = 0; i < 4; i++) begin
      seq[i].delete();
      for (int v = 11; v <= 13; v++) seq[i].push_back(8'(v));
      ordy[i] = 1'b0;
    end
    cycle();
    #2 rst_n = 1'b0;
    #1 reset_chk();
    for (int i = 0; i < 4; i++) begin
      hist[i].delete(); seq[i].delete(); pend[i] = 1'b0; wins[i] = 0; ordy[i] = 1'b1;
      for (int v = 21; v <= 24; v++) seq[i].push_back(8'(v));
    end
    @(posedge clk);
    #4 rst_n = 1'b1;
    repeat (8) cycle();
    chk("post_rst_wins", 0, wins[0], 1);
    chk("post_rst_wins", 1, wins[1], 1);
    chk("post_rst_wins", 2, wins[2], 3);
    chk("post_rst_wins", 3, wins[3], 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
